// File: rtl/bit_divider.sv
// bit_divider: 8-by-4 unsigned restoring divider, one quotient bit per clock.
// Define BIT_DIVIDER_ZERO_FAST_EN to finish B=0 requests without the RUN phase.
module bit_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] P,
   input  logic [3:0] B,
   output logic       ready,
   output logic       done,
   output logic [7:0] Q,
   output logic [3:0] R,
   output logic       div_zero,
   output logic       ovf
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0] st;
   logic [7:0] dvd, nq;
   logic [6:0] qt;
   logic [3:0] dvs, rem, nrem;
   logic [4:0] sh;
   logic [2:0] cnt;
   logic       qb;
   always_comb begin
      sh   = {rem, dvd[7]};
      qb   = sh >= {1'b0, dvs};
      nrem = qb ? sh[3:0] - dvs : sh[3:0];
      nq   = {qt, qb};
   end
   assign ready = st == IDLE;
   assign done  = st == DONE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st       <= IDLE;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         qt       <= '0;
         cnt      <= '0;
         Q        <= '0;
         R        <= '0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else
         case (st)
            IDLE: if (start) begin
`ifdef BIT_DIVIDER_ZERO_FAST_EN
               if (B == 4'd0) begin
                  st       <= DONE;
                  Q        <= 8'hFF;
                  R        <= P[3:0];
                  div_zero <= 1'b1;
                  ovf      <= 1'b1;
               end else begin
                  st  <= RUN;
                  dvd <= P;
                  dvs <= B;
                  rem <= '0;
                  qt  <= '0;
                  cnt <= '0;
               end
`else
               st  <= RUN;
               dvd <= P;
               dvs <= B;
               rem <= '0;
               qt  <= '0;
               cnt <= '0;
`endif
            end
            RUN: begin
               dvd <= {dvd[6:0], 1'b0};
               rem <= nrem;
               qt  <= nq[6:0];
               cnt <= cnt + 3'd1;
               // B=0 needs no special case: every step subtracts zero, giving Q=FF, R=P[3:0]
               if (cnt == 3'd7) begin
                  st       <= DONE;
                  Q        <= nq;
                  R        <= nrem;
                  div_zero <= dvs == 4'd0;
                  ovf      <= |nq[7:4];
               end
            end
            default: st <= IDLE;
         endcase
endmodule

// File: tb/tb_bit_divider.sv
// tb_bit_divider: directed and exhaustive checks of bit_divider against an arithmetic model.
module tb_bit_divider;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0] P = '0;
   logic [3:0] B = '0;
   logic       ready, done, div_zero, ovf;
   logic [7:0] Q;
   logic [3:0] R;
`ifdef BIT_DIVIDER_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   int errors = 0, checks = 0, k;

   bit_divider dut (.clk(clk), .rst(rst), .start(start), .P(P), .B(B), .ready(ready),
                    .done(done), .Q(Q), .R(R), .div_zero(div_zero), .ovf(ovf));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
      end
   endtask

   // model: edge count, last accepted edge, and result visible from edge acc+lat
   int         e = 0, acc = 0, lat = 8;
   bit         act = 1'b0, mdz = 1'b0, mov = 1'b0, pdz = 1'b0, pov = 1'b0;
   logic [7:0] mq = '0, pq = '0;
   logic [3:0] mr = '0, pr = '0;
   always @(posedge clk or posedge rst) begin : mdl
      int ne;
      if (rst) begin
         act <= 1'b0;
         mq  <= '0;
         mr  <= '0;
         mdz <= 1'b0;
         mov <= 1'b0;
      end else begin
         ne = e + 1;
         e <= ne;
         if (act && ne == acc + lat) begin
            mq  <= pq;
            mr  <= pr;
            mdz <= pdz;
            mov <= pov;
         end
         if ((!act || ne >= acc + lat + 2) && start) begin
            act <= 1'b1;
            acc <= ne;
            lat <= (B == 0 && FAST) ? 0 : 8;
            if (B == 0) begin
               pq  <= 8'hFF;
               pr  <= P[3:0];
               pdz <= 1'b1;
               pov <= 1'b1;
            end else begin
               pq  <= P / {4'd0, B};
               pr  <= 4'(P % {4'd0, B});
               pdz <= 1'b0;
               pov <= (P / {4'd0, B}) > 8'd15;
            end
            if (B == 0 && FAST) begin
               mq  <= 8'hFF;
               mr  <= P[3:0];
               mdz <= 1'b1;
               mov <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ready", ready, !act || e >= acc + lat + 1);
      chk("done", done, act && e == acc + lat);
      chk("Q", Q, mq);
      chk("R", R, mr);
      chk("div_zero", div_zero, mdz);
      chk("ovf", ovf, mov);
   end

   task automatic op(input logic [7:0] p, input logic [3:0] b, input bit lit, input logic [7:0] eq,
                     input logic [3:0] er, input bit eov, input bit edz, input int elat);
      int n = 0, c = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_wait", ready, 1);
      start = 1'b1;
      P = p;
      B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      P = 8'($urandom);
      B = 4'($urandom);
      while (!done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("latency", c, elat);
      if (lit) begin
         chk("lit_Q", Q, eq);
         chk("lit_R", R, er);
         chk("lit_ovf", ovf, eov);
         chk("lit_dz", div_zero, edz);
      end else begin
         if (b != 0) begin
            chk("QB+R", int'(Q) * int'(b) + int'(R), p);
            chk("R<B", R < b, 1);
         end
         chk("ovf_rule", ovf, Q > 15);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_Q", Q, 0);
      #2 rst = 1'b0;
      op(8'hE1, 4'hF, 1, 8'h0F, 4'd0, 0, 0, 8);
      op(8'd200, 4'd7, 1, 8'd28, 4'd4, 1, 0, 8);
      op(8'h5A, 4'd0, 1, 8'hFF, 4'hA, 1, 1, FAST ? 0 : 8);
      // abort mid-run: reset shortly after edge N+4
      @(negedge clk);
      start = 1'b1;
      P = 8'hE1;
      B = 4'hF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", ready, 1);
      chk("abort_done", done, 0);
      chk("abort_Q", Q, 0);
      chk("abort_R", R, 0);
      chk("abort_dz", div_zero, 0);
      chk("abort_ovf", ovf, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      op(8'd15, 4'd3, 1, 8'd5, 4'd0, 0, 0, 8);
      // start held high through RUN/DONE: second request waits for ready
      @(negedge clk);
      start = 1'b1;
      P = 8'd100;
      B = 4'd9;
      @(posedge clk);
      @(negedge clk);
      P = 8'd0;
      B = 4'd1;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("held_latency", k, 8);
      chk("held_Q", Q, 8'd11);
      chk("held_R", R, 4'd1);
      @(negedge clk);
      chk("held_ready", ready, 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("second_latency", k, 8);
      chk("second_Q", Q, 8'd0);
      chk("second_R", R, 4'd0);
      chk("second_ovf", ovf, 0);
      for (int p = 0; p < 256; p++)
         for (int b = 0; b < 16; b++)
            op(8'(p), 4'(b), 0, 8'd0, 4'd0, 0, 0, (b == 0 && FAST) ? 0 : 8);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bit_divider.md
BIT_DIVIDER -- requirements
Module: bit_divider

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled at rising edge of clk.
REQ-005 P  input  8  dividend (unsigned); captured when start is accepted.
REQ-006 B  input  4  divisor (unsigned); captured when start is accepted.
REQ-007 ready  output  1  high only in IDLE; start accepted when start=1 and ready=1.
REQ-008 done  output  1  one-cycle pulse; Q/R/flags valid from this cycle.
REQ-009 Q  output  8  quotient = P / B.
REQ-010 R  output  4  remainder = P mod B.
REQ-011 div_zero  output  1  captured B was 0.
REQ-012 ovf  output  1  Q > 15, i.e. quotient exceeds 4 bits; not a 4x4 product.

Function
REQ-013 FSM has states IDLE, RUN and DONE; encoding is free.
REQ-014 IDLE: on an accepted start, capture P and B, clear the 5-bit partial remainder, and go to RUN with iteration count 0.
REQ-015 RUN performs restoring division, MSB first, one quotient bit per edge:
- rem = {rem[3:0], dividend bit}.
- If rem >= {0,B}: subtract and set the quotient bit to 1.
- Otherwise: keep rem and set the quotient bit to 0.
REQ-016 After the 8th RUN iteration, go to DONE. Q, R=rem[3:0], div_zero and ovf are registered on the same edge.
REQ-017 Latency: start accepted at edge N; done is high in the cycle after edge N+8; IDLE and ready return at edge N+9.
REQ-018 DONE lasts exactly one cycle, then IDLE unconditionally.
REQ-019 start while ready=0 (RUN or DONE) is ignored; P and B changes are ignored after capture.
REQ-020 Back-to-back: start asserted in the cycle after done is accepted at the next edge.
REQ-021 Q, R, div_zero and ovf hold their values until the next DONE entry; they do not change during RUN.
REQ-022 B=0 result: Q=8'hFF, R=P[3:0], div_zero=1, ovf=1.
REQ-023 B=1 result: Q=P, R=0, with ovf set when P>15.
REQ-024 P < B result: Q=0, R=P[3:0], ovf=0.

Reset
REQ-025 rst=1 immediately forces IDLE, independent of clk.
REQ-026 While rst is high: ready=1 and done=0.
REQ-027 While rst is high: Q=0, R=0, div_zero=0, ovf=0, internal registers 0.
REQ-028 Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
REQ-029 The first edge after rst falls may accept start.

Configuration
REQ-030 Macro BIT_DIVIDER_ZERO_FAST_EN controls B=0 handling.
REQ-031 Macro defined: an accepted start with B=0 goes from IDLE directly to DONE.
- done is high in the cycle after edge N.
- Results are those of REQ-022.
REQ-032 Macro undefined: B=0 runs all 8 RUN iterations (latency per REQ-017) and yields the same REQ-022 results.
REQ-033 For B!=0, behaviour is identical with and without the macro.

Verification
REQ-034 P=8'hE1, B=4'hF -> done at N+9; Q=8'h0F, R=0, ovf=0, div_zero=0.
REQ-035 P=8'd200, B=4'd7 -> Q=8'd28, R=4'd4, ovf=1, div_zero=0.
REQ-036 P=8'h5A, B=0 -> Q=8'hFF, R=4'hA, div_zero=1, ovf=1.
- Macro defined: done at N+1.
- Macro undefined: done at N+9.
REQ-037 P=8'd100, B=4'd9 accepted; then start held high with P=0, B=1 during RUN.
- Exactly one done, with Q=8'd11, R=4'd1.
- The second request is accepted only after ready returns.
REQ-038 rst pulsed at edge N+4 of an operation -> no done pulse, all outputs 0, ready=1; the next start P=8'd15, B=4'd3 gives Q=5, R=0.
REQ-039 Exhaustive sweep of all 4096 (P,B) pairs, back-to-back:
- B!=0: Q*B+R==P and R<B.
- B=0: results per REQ-022.
- ovf==(Q>15) for every pair.
